aes_128_key_sched: RTL and testbench

On-the-fly AES-128 round-key generator that sits directly upstream of the AES-128 core and drives its `key_round` input. It holds the cipher key and presents round key 0. On each `key_ready` request from the core it computes the next round key (RotWord/SubWord/Rcon) in one cycle. After round 10 it wraps back to round key 0 for the next block, so round keys are never stored in a table.

---
 rtl/aes_128_key_sched.sv | 87 ++++++++
 tb/tb_aes_128_key_sched.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_128_key_sched.sv
// aes_128_key_sched: on-the-fly AES-128 round-key generator, one round key per key_ready.
// Holds the cipher key and re-derives round keys each block instead of storing a table.
module aes_128_key_sched (
    input  logic         clk,
    input  logic         kill,
    input  logic [127:0] key_in,
    input  logic         key_load,
    input  logic         key_ready,
    output logic [127:0] key_round,
    output logic [3:0]   round,
    output logic         key_valid,
    output logic         busy,
    output logic         key_err
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };
    // Entry r is the Rcon used for the step out of round r; entry 10 is a never-used pad.
    localparam logic [87:0] RCON = 88'h01020408102040801b3600;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    logic [127:0] base_key_q, base_key_d, key_round_q, key_round_d, key_next;
    logic [3:0]   round_q, round_d;
    logic         key_valid_q, key_valid_d, key_err_q, key_err_d;
    logic         adv, load_ok, last;
    logic [31:0]  w0, w1, w2, w3, sub_rot;
    logic [7:0]   rc;

    always_comb begin
        sub_rot     = {sbox(key_round_q[23:16]), sbox(key_round_q[15:8]),
                       sbox(key_round_q[7:0]), sbox(key_round_q[31:24])};
        rc          = RCON[{4'd10 - round_q, 3'b000} +: 8];
        w0          = key_round_q[127:96] ^ sub_rot ^ {rc, 24'h0};
        w1          = key_round_q[95:64] ^ w0;
        w2          = key_round_q[63:32] ^ w1;
        w3          = key_round_q[31:0] ^ w2;
        key_next    = {w0, w1, w2, w3};
        last        = round_q == 4'd10;
        adv         = key_ready & key_valid_q;
        load_ok     = key_load & (round_q == 4'd0) & ~key_ready;
        key_err_d   = key_load & ((round_q != 4'd0) | adv);
        key_valid_d = key_valid_q | load_ok;
        base_key_d  = load_ok ? key_in : base_key_q;
        key_round_d = load_ok ? key_in : adv ? (last ? base_key_q : key_next) : key_round_q;
        round_d     = load_ok ? 4'd0 : adv ? (last ? 4'd0 : round_q + 4'd1) : round_q;
    end

    always_ff @(posedge clk or negedge kill) begin
        if (!kill) begin
            base_key_q  <= '0;
            key_round_q <= '0;
            round_q     <= '0;
            key_valid_q <= 1'b0;
            key_err_q   <= 1'b0;
        end else begin
            base_key_q  <= base_key_d;
            key_round_q <= key_round_d;
            round_q     <= round_d;
            key_valid_q <= key_valid_d;
            key_err_q   <= key_err_d;
        end
    end

    assign key_round = key_round_q;
    assign round     = round_q;
    assign key_valid = key_valid_q;
    assign key_err   = key_err_q;
    assign busy      = round_q != 4'd0;
endmodule

// File: tb/tb_aes_128_key_sched.sv
// tb_aes_128_key_sched: directed and random checks of aes_128_key_sched against a
// reference built from GF(2^8) arithmetic and a precomputed 11-entry round-key list.
module tb_aes_128_key_sched;
    logic         clk = 1'b0, kill = 1'b0, key_load = 1'b0, key_ready = 1'b0;
    logic [127:0] key_in = '0, key_round;
    logic [3:0]   round;
    logic         key_valid, busy, key_err;
    logic [135:0] obs;
    int           checks = 0, errors = 0;

    logic [7:0]   sb [256];
    logic [127:0] rk [11];
    int           m_rnd = 0;
    bit           m_valid = 0, m_err = 0;

    aes_128_key_sched dut (
        .clk(clk), .kill(kill), .key_in(key_in), .key_load(key_load), .key_ready(key_ready),
        .key_round(key_round), .round(round), .key_valid(key_valid), .busy(busy), .key_err(key_err)
    );

    always #5 clk = ~clk;
    assign obs = {key_round, round, key_valid, busy, key_err};

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] expand_m(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w [4];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        t = {w[3][23:0], w[3][31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        w[0] = w[0] ^ t ^ {rc, 24'h0};
        for (int i = 1; i < 4; i++) w[i] = w[i] ^ w[i - 1];
        return {w[0], w[1], w[2], w[3]};
    endfunction

    task automatic build_sched(input logic [127:0] k);
        logic [7:0] rc;
        rc = 8'h01;
        rk[0] = k;
        for (int i = 1; i <= 10; i++) begin
            rk[i] = expand_m(rk[i - 1], rc);
            rc = gmul(rc, 8'h02);
        end
    endtask

    function automatic logic [135:0] exp_vec();
        return {m_valid ? rk[m_rnd] : 128'h0, 4'(m_rnd), m_valid, m_rnd != 0, m_err};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive(input bit ld, input bit rd, input logic [127:0] k);
        bit acc;
        acc = rd && m_valid;
        key_load = ld; key_ready = rd; key_in = k;
        m_err = ld && (m_rnd != 0 || acc);
        if (ld && m_rnd == 0 && !rd) begin
            m_valid = 1; m_rnd = 0; build_sched(k);
        end else if (acc) m_rnd = (m_rnd == 10) ? 0 : m_rnd + 1;
        @(posedge clk); #1;
        key_load = 0; key_ready = 0;
    endtask

    task automatic model_reset();
        m_valid = 0; m_rnd = 0; m_err = 0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        checks++;
        if (obs !== 136'h0) begin errors++; $display("FAIL reset_hold got %h exp 0", obs); end
        kill = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(0, i >= 2, '0);
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL reset_idle %0d got %h exp %h", i, obs, exp_vec()); end
        end
    endtask

    task automatic test_fips();
        logic [127:0] k;
        k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        drive(1, 0, k);
        checks++;
        if (key_round !== k || round !== 4'd0 || key_valid !== 1'b1) begin
            errors++; $display("FAIL fips_load got %h r%0d v%b exp %h r0 v1", key_round, round, key_valid, k);
        end
        for (int i = 1; i <= 10; i++) begin
            drive(0, 1, '0);
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL fips_step %0d got %h exp %h", i, obs, exp_vec()); end
            if (i == 1) begin
                checks++;
                if (key_round !== 128'ha0fafe1788542cb123a339392a6c7605) begin
                    errors++; $display("FAIL fips_r1 got %h exp a0fafe1788542cb123a339392a6c7605", key_round);
                end
            end
            if (i == 10) begin
                checks++;
                if (key_round !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 || round !== 4'd10) begin
                    errors++; $display("FAIL fips_r10 got %h r%0d exp d014f9a8c9ee2589e13f0cc8b6630ca6 r10", key_round, round);
                end
            end
            drive(0, 0, '0);
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL fips_hold %0d got %h exp %h", i, obs, exp_vec()); end
        end
        drive(0, 1, '0);
        checks++;
        if (key_round !== k || round !== 4'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL fips_wrap got %h r%0d exp %h r0", key_round, round, k);
        end
    endtask

    task automatic test_back_to_back();
        drive(1, 0, '0);
        for (int i = 1; i <= 11; i++) begin
            drive(0, 1, '0);
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL b2b_step %0d got %h exp %h", i, obs, exp_vec()); end
            if (i == 1) begin
                checks++;
                if (key_round !== 128'h62636363626363636263636362636363) begin
                    errors++; $display("FAIL zero_r1 got %h exp 62636363626363636263636362636363", key_round);
                end
            end
            if (i == 10) begin
                checks++;
                if (key_round !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
                    errors++; $display("FAIL zero_r10 got %h exp b4ef5bcb3e92e21123e951cf6f8f188e", key_round);
                end
            end
        end
    endtask

    task automatic test_reject();
        drive(1, 0, rand128());
        for (int i = 0; i < 4; i++) drive(0, 1, '0);
        drive(1, 0, rand128());
        checks++;
        if (key_err !== 1'b1 || round !== 4'd4 || obs !== exp_vec()) begin
            errors++; $display("FAIL reject_busy got %h exp %h", obs, exp_vec());
        end
        drive(0, 0, '0);
        checks++;
        if (key_err !== 1'b0 || obs !== exp_vec()) begin
            errors++; $display("FAIL reject_pulse got %h exp %h", obs, exp_vec());
        end
        for (int i = 0; i < 7; i++) begin
            drive(0, 1, '0);
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL reject_sweep %0d got %h exp %h", i, obs, exp_vec()); end
        end
        drive(1, 1, rand128());
        checks++;
        if (key_err !== 1'b1 || round !== 4'd1 || obs !== exp_vec()) begin
            errors++; $display("FAIL reject_ready got %h exp %h", obs, exp_vec());
        end
        for (int i = 0; i < 10; i++) drive(0, 1, '0);
        checks++;
        if (obs !== exp_vec()) begin errors++; $display("FAIL reject_end got %h exp %h", obs, exp_vec()); end
    endtask

    task automatic test_reset_mid();
        drive(1, 0, rand128());
        for (int i = 0; i < 6; i++) drive(0, 1, '0);
        checks++;
        if (round !== 4'd6) begin errors++; $display("FAIL mid_pre got r%0d exp r6", round); end
        kill = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs !== 136'h0) begin errors++; $display("FAIL mid_async got %h exp 0", obs); end
        @(posedge clk); #1;
        kill = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, '0);
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL mid_ignored %0d got %h exp %h", i, obs, exp_vec()); end
        end
    endtask

    task automatic test_reload();
        logic [127:0] b;
        drive(1, 0, rand128());
        for (int i = 0; i < 11; i++) drive(0, 1, '0);
        b = rand128();
        drive(1, 0, b);
        checks++;
        if (key_round !== b || round !== 4'd0 || key_err !== 1'b0 || key_valid !== 1'b1) begin
            errors++; $display("FAIL reload got %h r%0d e%b exp %h r0 e0", key_round, round, key_err, b);
        end
        drive(0, 1, '0);
        checks++;
        if (obs !== exp_vec()) begin errors++; $display("FAIL reload_step got %h exp %h", obs, exp_vec()); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, rand128());
            checks++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL random %0d got %h exp %h", i, obs, exp_vec()); end
        end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_fips();
        test_back_to_back();
        test_reject();
        test_reset_mid();
        test_reload();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
